// File: rtl/micro_sequencer.sv
// micro_sequencer
// Microprogram sequencer that generates the next microinstruction address
// for decode_rom every cycle. It handles instruction fetch, opcode dispatch,
// stepping within a 4-word microroutine, interrupt entry and trapping of
// microroutine overruns.
//
// Each opcode owns a 4-word microroutine at {opcode, step[1:0]}. decode_rom
// registers addr on the clock edge, so addr is the combinational next-state
// value and upc is the address whose control word decode_rom presents now.
//
// Ports:
//   clk         in   1       single clock, posedge
//   rst         in   1       asynchronous, active-high reset
//   ir_op       in   8       opcode from the instruction register (dispatch only)
//   uc_dispatch in   1       control-word bit: jump to {ir_op, 2'b00}
//   uc_end      in   1       control-word bit: last word of the routine
//   stall       in   1       memory not ready: hold the current microinstruction
//   irq         in   1       level interrupt request
//   irq_en      in   1       interrupt enable from the CPU flags
//   addr        out  10      next microaddress to decode_rom (combinational)
//   upc         out  10      current microaddress (registered)
//   irq_ack     out  1       high for the first cycle of the IRQ routine
//   fault       out  1       sticky microroutine-overrun flag
//   retired     out  CNT_W   count of non-stalled uc_end events (wraps)

module micro_sequencer #(
    parameter logic [9:0] FETCH_ADDR = 10'h000,
    parameter logic [9:0] IRQ_ADDR   = 10'h3FC,
    parameter logic [9:0] FAULT_ADDR = 10'h3F8,
    parameter int         CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       ir_op,
    input  logic             uc_dispatch,
    input  logic             uc_end,
    input  logic             stall,
    input  logic             irq,
    input  logic             irq_en,
    output logic [9:0]       addr,
    output logic [9:0]       upc,
    output logic             irq_ack,
    output logic             fault,
    output logic [CNT_W-1:0] retired
);

    logic take_irq;
    logic take_retire;
    logic take_fault;

    // Next-address priority chain. The event strobes are decoded alongside
    // so that the registered flags and counter follow exactly the rule that
    // selected the address. A simultaneous uc_end is ignored on dispatch.
    always_comb begin
        addr        = upc + 10'd1;
        take_irq    = 1'b0;
        take_retire = 1'b0;
        take_fault  = 1'b0;
        if (fault) begin
            addr = FAULT_ADDR;
        end else if (rst) begin
            addr = FETCH_ADDR;
        end else if (stall) begin
            addr = upc;
        end else if (uc_dispatch) begin
            addr = {ir_op, 2'b00};
        end else if (uc_end && irq && irq_en) begin
            addr        = IRQ_ADDR;
            take_irq    = 1'b1;
            take_retire = 1'b1;
        end else if (uc_end) begin
            addr        = FETCH_ADDR;
            take_retire = 1'b1;
        end else if (upc[1:0] == 2'b11) begin
            // Stepping past the last word would cross into the next
            // opcode's routine, so trap instead.
            addr       = FAULT_ADDR;
            take_fault = 1'b1;
        end
    end

    // State register. irq_ack is a one-cycle pulse because it is reloaded
    // every edge and take_irq is never set while stalled. fault only clears
    // through reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upc     <= FETCH_ADDR;
            irq_ack <= 1'b0;
            fault   <= 1'b0;
            retired <= '0;
        end else begin
            upc     <= addr;
            irq_ack <= take_irq;
            fault   <= fault | take_fault;
            if (take_retire) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer
// Directed testbench for micro_sequencer. The driver applies one cycle of
// inputs and pushes the hand-computed response for that cycle into a
// scoreboard queue. A monitor on the falling edge pops and compares.

module tb_micro_sequencer;

    logic        clk;
    logic        rst;
    logic [7:0]  ir_op;
    logic        uc_dispatch;
    logic        uc_end;
    logic        stall;
    logic        irq;
    logic        irq_en;
    logic [9:0]  addr;
    logic [9:0]  upc;
    logic        irq_ack;
    logic        fault;
    logic [15:0] retired;

    typedef struct {
        logic [9:0]  addr;
        logic [9:0]  upc;
        logic        ack;
        logic        fault;
        logic [15:0] ret;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    micro_sequencer #(.CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .ir_op       (ir_op),
        .uc_dispatch (uc_dispatch),
        .uc_end      (uc_end),
        .stall       (stall),
        .irq         (irq),
        .irq_en      (irq_en),
        .addr        (addr),
        .upc         (upc),
        .irq_ack     (irq_ack),
        .fault       (fault),
        .retired     (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one field and record the outcome.
    task automatic checkOutput(input string name, input string field,
                               input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s.%s actual=%h expected=%h", name, field, actual, expected);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge and queue the
    // expected state and next address for that cycle.
    // ctl = {rst, stall, uc_dispatch, uc_end, irq, irq_en}
    task automatic applyStimulus(input logic [5:0] ctl, input logic [7:0] op,
                                 input logic [9:0] e_upc, input logic e_ack,
                                 input logic e_fault, input logic [15:0] e_ret,
                                 input logic [9:0] e_addr, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        {rst, stall, uc_dispatch, uc_end, irq, irq_en} = ctl;
        ir_op   = op;
        e.addr  = e_addr;
        e.upc   = e_upc;
        e.ack   = e_ack;
        e.fault = e_fault;
        e.ret   = e_ret;
        e.name  = name;
        sb.push_back(e);
    endtask

    // Monitor: the DUT presents a full response every cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checkOutput(e.name, "addr",    {6'd0, addr},    {6'd0, e.addr});
            checkOutput(e.name, "upc",     {6'd0, upc},     {6'd0, e.upc});
            checkOutput(e.name, "irq_ack", {15'd0, irq_ack}, {15'd0, e.ack});
            checkOutput(e.name, "fault",   {15'd0, fault},   {15'd0, e.fault});
            checkOutput(e.name, "retired", retired,          e.ret);
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst = 1'b1; stall = 1'b0; uc_dispatch = 1'b0; uc_end = 1'b0;
        irq = 1'b0; irq_en = 1'b0; ir_op = 8'h00;

        //            rst stl dsp end irq en
        applyStimulus(6'b100000, 8'h00, 10'h000, 0, 0, 16'd0, 10'h000, "reset");
        applyStimulus(6'b000000, 8'h00, 10'h000, 0, 0, 16'd0, 10'h001, "fetch0");
        applyStimulus(6'b001000, 8'h12, 10'h001, 0, 0, 16'd0, 10'h048, "dispatch12");
        applyStimulus(6'b000000, 8'h00, 10'h048, 0, 0, 16'd0, 10'h049, "step048");
        applyStimulus(6'b000000, 8'h00, 10'h049, 0, 0, 16'd0, 10'h04A, "step049");
        applyStimulus(6'b000100, 8'h00, 10'h04A, 0, 0, 16'd0, 10'h000, "end04A");
        applyStimulus(6'b000000, 8'h00, 10'h000, 0, 0, 16'd1, 10'h001, "fetch1");
        applyStimulus(6'b001000, 8'h12, 10'h001, 0, 0, 16'd1, 10'h048, "dispatch12b");
        applyStimulus(6'b000000, 8'h00, 10'h048, 0, 0, 16'd1, 10'h049, "step048b");
        applyStimulus(6'b010100, 8'h00, 10'h049, 0, 0, 16'd1, 10'h049, "stall1");
        applyStimulus(6'b010100, 8'h00, 10'h049, 0, 0, 16'd1, 10'h049, "stall2");
        applyStimulus(6'b010100, 8'h00, 10'h049, 0, 0, 16'd1, 10'h049, "stall3");
        applyStimulus(6'b000100, 8'h00, 10'h049, 0, 0, 16'd1, 10'h000, "stall_release");
        applyStimulus(6'b000111, 8'h00, 10'h000, 0, 0, 16'd2, 10'h3FC, "irq_take");
        applyStimulus(6'b010000, 8'h00, 10'h3FC, 1, 0, 16'd3, 10'h3FC, "irq_ack_stall");
        applyStimulus(6'b000110, 8'h00, 10'h3FC, 0, 0, 16'd3, 10'h000, "irq_repeat_noack");
        applyStimulus(6'b000110, 8'h00, 10'h000, 0, 0, 16'd4, 10'h000, "irq_masked");
        applyStimulus(6'b001111, 8'h05, 10'h000, 0, 0, 16'd5, 10'h014, "dispatch_and_end");
        applyStimulus(6'b000000, 8'h00, 10'h014, 0, 0, 16'd5, 10'h015, "ovr014");
        applyStimulus(6'b000000, 8'h00, 10'h015, 0, 0, 16'd5, 10'h016, "ovr015");
        applyStimulus(6'b000000, 8'h00, 10'h016, 0, 0, 16'd5, 10'h017, "ovr016");
        applyStimulus(6'b000000, 8'h00, 10'h017, 0, 0, 16'd5, 10'h3F8, "ovr017");
        applyStimulus(6'b001000, 8'h12, 10'h3F8, 0, 1, 16'd5, 10'h3F8, "fault_dispatch");
        applyStimulus(6'b010111, 8'h00, 10'h3F8, 0, 1, 16'd5, 10'h3F8, "fault_stall_end");
        applyStimulus(6'b100000, 8'h00, 10'h000, 0, 0, 16'd0, 10'h000, "fault_reset");
        applyStimulus(6'b000000, 8'h00, 10'h000, 0, 0, 16'd0, 10'h001, "post_reset");
        applyStimulus(6'b000100, 8'h00, 10'h001, 0, 0, 16'd0, 10'h000, "wrap_start");

        // Retire at the fetch slot every cycle until the counter is full.
        uc_end = 1'b1;
        repeat (65534) @(posedge clk);

        applyStimulus(6'b000100, 8'h00, 10'h000, 0, 0, 16'hFFFF, 10'h000, "wrap_full");
        applyStimulus(6'b000000, 8'h00, 10'h000, 0, 0, 16'h0000, 10'h001, "wrap_zero");
        applyStimulus(6'b000000, 8'h00, 10'h001, 0, 0, 16'h0000, 10'h002, "wrap_step");

        @(negedge clk);
        @(negedge clk);
        checkOutput("scoreboard", "pending", 16'(sb.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
